ram_4wide_ctrl: RTL and testbench
=================================

// Module: ram_4wide_ctrl
// PURPOSE
//  Front-end controller for the 4-port register RAM (4 write / 4 read ports, 1-cycle registered read).
//  After reset it zero-sweeps every entry. It then arbitrates NREQ write requesters onto the 4 RAM write ports.
//  Arbitration is round-robin with at most one grant per address per cycle. Reads pass through, gated by init and write-hazard rules.
// PARAMETERS
//  ADDR_WIDTH  5   RAM address bits; must be >= 2 (depth 2**ADDR_WIDTH, a multiple of 4)
//  DATA_WIDTH  32  RAM word width
//  NPORTS      4   RAM ports; fixed at 4, other values unsupported
//  NREQ        8   write requesters; 4 <= NREQ <= 16
// PORTS
//  clk            in   1                      clock
//  rst            in   1                      synchronous, active-high reset
//  req_valid      in   NREQ                   write request valid per requester
//  req_ready      out  NREQ                   grant; a write is taken on valid&ready
//  req_addr       in   NREQ*ADDR_WIDTH        write address per requester
//  req_data       in   NREQ*DATA_WIDTH        write data per requester
//  rd_valid       in   NPORTS                 read request per read lane
//  rd_addr        in   NPORTS*ADDR_WIDTH      read address per lane
//  rd_ready       out  1                      common read accept for all lanes
//  rd_data_valid  out  NPORTS                 read data valid, 1 cycle after accept
//  rd_data        out  NPORTS*DATA_WIDTH      read data per lane
//  ram_wr_en      out  NPORTS                 to RAM wr_en
//  ram_wr_addr    out  NPORTS*ADDR_WIDTH      to RAM wr_addr
//  ram_wr_data    out  NPORTS*DATA_WIDTH      to RAM wr_data
//  ram_rd_addr    out  NPORTS*ADDR_WIDTH      to RAM rd_addr (= rd_addr, combinational)
//  ram_rd_data    in   NPORTS*DATA_WIDTH      from RAM rd_data (registered in RAM)
//  init_done      out  1                      high once in RUN
// BEHAVIOUR
//  FSM INIT->RUN. Reset: state=INIT, sweep cnt=0, rr ptr=0, rd_data_valid=0.
//  While rst=1: init_done=0; req_ready=0; rd_ready=0; ram_wr_en=0.
//  INIT: each cycle ram_wr_en=4'b1111, port p writes addr cnt*4+p with data 0; cnt++.
//    After 2**ADDR_WIDTH/4 cycles -> RUN; init_done=1 from the next cycle.
//    In INIT: req_ready=0 and rd_ready=0.
//  RUN write arbitration (combinational, same cycle):
//    Scan requesters ptr, ptr+1, ... mod NREQ.
//    Grant a valid requester if fewer than 4 grants so far and its addr differs from every addr already granted this cycle.
//    The k-th grant drives RAM port k (ports 0..k-1 used); unused ports have ram_wr_en=0.
//    req_ready[i]=grant[i]. A deferred same-address request is retried next cycle.
//    ptr <= (index of last granted requester + 1) mod NREQ when any grant is made; else ptr is unchanged.
//    Granted addresses are distinct, so RAM port write order never matters.
//  Reads: ram_rd_addr=rd_addr always.
//    rd_data_valid[j] <= rd_valid[j] & rd_ready; rd_data = ram_rd_data, except on the forward path below.
//  Hazard: a read lane hits when rd_valid[j] and rd_addr[j] equals any granted write addr in the same cycle.
//  Reset mid-operation: rst aborts everything. In-flight rd_data_valid clears; INIT restarts at cnt=0; ptr=0.
//    Requests are not latched, so nothing is lost inside the block.
// CONFIGURATION
//  RAM_CTRL_FWD_EN defined:
//    rd_ready = (state==RUN), regardless of hazards.
//    A hit lane registers the matching write data; next cycle rd_data[j] = that data (write-before-read).
//  RAM_CTRL_FWD_EN undefined:
//    rd_ready = (state==RUN) & no lane hits. A hazard stalls all lanes for that cycle.
//    The read is accepted on a later hazard-free cycle and returns the new value from the RAM.
// TESTING
//  rst 1 cycle, ADDR_WIDTH=5 -> 8 INIT cycles, ram_wr_en=1111 with addrs 0..31 and data 0; init_done=1 on cycle 9.
//  RUN, ptr=0, req0..4 valid, addrs 1..5 -> req_ready=0x0F, ports0-3 get req0-3; next cycle req4 on port0, ptr=5.
//  req0 and req1 both addr 7, ptr=0 -> only req0 granted; req1 granted next cycle on port0.
//  Write addr 3 data 0xDEAD + rd lane0 addr 3, FWD_EN -> rd_ready=1; next cycle rd_data_valid[0]=1, rd_data[0]=0xDEAD.
//  Same stimulus without FWD_EN -> rd_ready=0 that cycle; read accepted next cycle; rd_data[0]=0xDEAD the cycle after.
//  All 8 req valid (distinct addrs) for 4 cycles -> grants alternate 0x0F,0xF0,0x0F,0xF0.
//  rst asserted mid-RUN -> init_done=0, req_ready=0, rd_data_valid=0, INIT sweep restarts at addr 0.

Source files
------------

// File: rtl/ram_4wide_ctrl.sv
// ram_4wide_ctrl: zero-sweeps the 4-port RAM, then round-robin arbitrates NREQ writers onto 4 write ports.
// Define RAM_CTRL_FWD_EN to forward same-cycle write data to hitting reads instead of stalling them.
module ram_4wide_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NPORTS     = 4,
   parameter int NREQ       = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req_valid,
   output logic [NREQ-1:0]              req_ready,
   input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
   input  logic [NPORTS-1:0]            rd_valid,
   input  logic [NPORTS*ADDR_WIDTH-1:0] rd_addr,
   output logic                         rd_ready,
   output logic [NPORTS-1:0]            rd_data_valid,
   output logic [NPORTS*DATA_WIDTH-1:0] rd_data,
   output logic [NPORTS-1:0]            ram_wr_en,
   output logic [NPORTS*ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [NPORTS*DATA_WIDTH-1:0] ram_wr_data,
   output logic [NPORTS*ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [NPORTS*DATA_WIDTH-1:0] ram_rd_data,
   output logic                         init_done
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int PW    = $clog2(NREQ);
   localparam int CW    = ADDR_WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH/4 - 1);

   typedef enum logic {INIT, RUN} state_t;
   state_t r_state, w_state_nx;

   logic [CW-1:0]                         r_cnt;
   logic [PW-1:0]                         r_ptr, w_ptr_nx;
   logic [NPORTS-1:0]                     r_rdv;
   logic [NREQ-1:0]                       w_grant;
   logic [NPORTS-1:0]                     w_we, w_hit;
   logic [NPORTS-1:0][ADDR_WIDTH-1:0]     w_wa, w_rda;
   logic [NPORTS-1:0][DATA_WIDTH-1:0]     w_wd, w_rrd, w_rdd;
   logic [NREQ-1:0][ADDR_WIDTH-1:0]       w_ra;
   logic [NREQ-1:0][DATA_WIDTH-1:0]       w_rqd;
   logic                                  w_run;

   assign w_ra        = req_addr;
   assign w_rqd       = req_data;
   assign w_rda       = rd_addr;
   assign w_rrd       = ram_rd_data;
   assign w_run       = (r_state == RUN) && !rst;
   assign init_done   = w_run;
   assign req_ready   = w_grant;
   assign ram_wr_en   = w_we;
   assign ram_wr_addr = w_wa;
   assign ram_wr_data = w_wd;
   assign ram_rd_addr = rd_addr;
   assign rd_data     = w_rdd;
   assign rd_data_valid = r_rdv;

   always_comb begin
      w_state_nx = (r_state == INIT && r_cnt == LAST) ? RUN : r_state;
   end

   // Write-port assignment: sweep in INIT, first-fit distinct-address grants in RUN
   always_comb begin : arb
      logic [2:0]      n;
      logic [PW-1:0]   idx;
      logic            clash;
      w_grant  = '0;
      w_we     = '0;
      w_wa     = '0;
      w_wd     = '0;
      w_ptr_nx = r_ptr;
      n        = '0;
      idx      = '0;
      clash    = 1'b0;
      if (!rst && r_state == INIT) begin
         for (int p = 0; p < NPORTS; p++) begin
            w_we[p] = 1'b1;
            w_wa[p] = ADDR_WIDTH'({r_cnt, 2'(p)});
         end
      end else if (w_run) begin
         for (int k = 0; k < NREQ; k++) begin
            idx   = PW'((int'(r_ptr) + k) % NREQ);
            clash = 1'b0;
            for (int q = 0; q < NPORTS; q++)
               if (3'(q) < n && w_wa[q] == w_ra[idx]) clash = 1'b1;
            if (req_valid[idx] && !n[2] && !clash) begin
               w_grant[idx] = 1'b1;
               w_we[n[1:0]] = 1'b1;
               w_wa[n[1:0]] = w_ra[idx];
               w_wd[n[1:0]] = w_rqd[idx];
               w_ptr_nx     = PW'((int'(idx) + 1) % NREQ);
               n            = n + 3'd1;
            end
         end
      end
   end

`ifdef RAM_CTRL_FWD_EN
   logic [NPORTS-1:0]                 r_fh;
   logic [NPORTS-1:0][DATA_WIDTH-1:0] r_fd, w_fd;
   always_comb begin
      w_hit = '0;
      w_fd  = '0;
      for (int j = 0; j < NPORTS; j++)
         for (int q = 0; q < NPORTS; q++)
            if (rd_valid[j] && w_we[q] && w_run && w_rda[j] == w_wa[q]) begin
               w_hit[j] = 1'b1;
               w_fd[j]  = w_wd[q];
            end
      for (int j = 0; j < NPORTS; j++)
         w_rdd[j] = r_fh[j] ? r_fd[j] : w_rrd[j];
   end
   assign rd_ready = w_run;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fh <= '0;
         r_fd <= '0;
      end else begin
         r_fh <= w_hit & {NPORTS{rd_ready}};
         r_fd <= w_fd;
      end
   end
`else
   always_comb begin
      w_hit = '0;
      for (int j = 0; j < NPORTS; j++)
         for (int q = 0; q < NPORTS; q++)
            if (rd_valid[j] && w_we[q] && w_run && w_rda[j] == w_wa[q]) w_hit[j] = 1'b1;
   end
   assign w_rdd    = w_rrd;
   assign rd_ready = w_run && !(|w_hit);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_rdv   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= (r_state == INIT) ? r_cnt + 1'b1 : r_cnt;
         r_ptr   <= w_ptr_nx;
         r_rdv   <= rd_valid & {NPORTS{rd_ready}};
      end
   end
endmodule

// File: tb/tb_ram_4wide_ctrl.sv
// tb_ram_4wide_ctrl: directed checks of sweep, arbitration, hazards and reset for ram_4wide_ctrl.
// Expectations follow RAM_CTRL_FWD_EN when the bench is built with it defined.
module tb_ram_4wide_ctrl;
   logic                 clk = 1'b0;
   logic                 rst;
   logic [7:0]           rv, rr;
   logic [7:0][4:0]      ra;
   logic [7:0][31:0]     rdt;
   logic [3:0]           rdv, rdvo, we;
   logic [3:0][4:0]      rda, wa, rra;
   logic                 rd_ready, init_done;
   logic [3:0][31:0]     rdd, wd, rro;
   logic [31:0]          mem [32];
   int                   n_tests = 0;
   int                   n_fail  = 0;

   always #5 clk = ~clk;

   ram_4wide_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(rv), .req_ready(rr), .req_addr(ra), .req_data(rdt),
      .rd_valid(rdv), .rd_addr(rda), .rd_ready(rd_ready),
      .rd_data_valid(rdvo), .rd_data(rdd),
      .ram_wr_en(we), .ram_wr_addr(wa), .ram_wr_data(wd),
      .ram_rd_addr(rra), .ram_rd_data(rro), .init_done(init_done)
   );

   // Behavioural 4W/4R RAM with registered read
   always_ff @(posedge clk) begin
      for (int p = 0; p < 4; p++) begin
         if (we[p]) mem[wa[p]] <= wd[p];
         rro[p] <= mem[rra[p]];
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; rv = '0; ra = '0; rdt = '0; rdv = '0; rda = '0;
      #1;
      chk("rst_init_done", 128'(init_done), 0);
      chk("rst_req_ready", 128'(rr), 0);
      chk("rst_wr_en", 128'(we), 0);
      chk("rst_rd_ready", 128'(rd_ready), 0);
      tick();
      rst = 1'b0; rv = 8'hFF;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("init_wr_en", 128'(we), 128'hF);
         chk("init_wr_addr", 128'(wa), 128'({5'(c*4+3), 5'(c*4+2), 5'(c*4+1), 5'(c*4)}));
         chk("init_wr_data", 128'(wd), 0);
         chk("init_req_ready", 128'(rr), 0);
         chk("init_rd_ready", 128'(rd_ready), 0);
         chk("init_done_low", 128'(init_done), 0);
         tick();
      end
      rv = '0;
      #1;
      chk("run_init_done", 128'(init_done), 1);
      chk("run_idle_wr_en", 128'(we), 0);
      // five requesters, ptr=0
      rv = 8'h1F;
      for (int i = 0; i < 5; i++) begin ra[i] = 5'(i + 1); rdt[i] = 32'h100 + 32'(i); end
      #1;
      chk("rr5_ready", 128'(rr), 128'h0F);
      chk("rr5_wr_en", 128'(we), 128'hF);
      chk("rr5_wr_addr", 128'(wa), 128'({5'd4, 5'd3, 5'd2, 5'd1}));
      chk("rr5_wr_data", 128'(wd), 128'({32'h103, 32'h102, 32'h101, 32'h100}));
      tick();
      rv = 8'h10;
      #1;
      chk("rr5b_ready", 128'(rr), 128'h10);
      chk("rr5b_wr_en", 128'(we), 128'h1);
      chk("rr5b_addr0", 128'(wa[0]), 5);
      chk("rr5b_data0", 128'(wd[0]), 128'h104);
      tick();
      // ptr=5: req7 alone moves ptr to 0
      rv = 8'h80; ra[7] = 5'd9; rdt[7] = 32'h77;
      #1;
      chk("ptr5_ready", 128'(rr), 128'h80);
      tick();
      // same-address conflict
      rv = 8'h03; ra[0] = 5'd7; ra[1] = 5'd7; rdt[0] = 32'hA0; rdt[1] = 32'hA1;
      #1;
      chk("same_ready", 128'(rr), 128'h01);
      chk("same_wr_en", 128'(we), 128'h1);
      chk("same_addr0", 128'(wa[0]), 7);
      tick();
      rv = 8'h02;
      #1;
      chk("same_retry_ready", 128'(rr), 128'h02);
      chk("same_retry_data0", 128'(wd[0]), 128'hA1);
      tick();
      // ptr=2: bring back to 0
      rv = 8'h80;
      #1;
      chk("ptr2_ready", 128'(rr), 128'h80);
      tick();
      // all eight requesters for four cycles
      rv = 8'hFF;
      for (int i = 0; i < 8; i++) begin ra[i] = 5'(10 + i); rdt[i] = 32'h200 + 32'(i); end
      #1;
      chk("all8_c0", 128'(rr), 128'h0F);
      tick();
      chk("all8_c1", 128'(rr), 128'hF0);
      chk("all8_c1_addr0", 128'(wa[0]), 14);
      tick();
      chk("all8_c2", 128'(rr), 128'h0F);
      tick();
      chk("all8_c3", 128'(rr), 128'hF0);
      tick();
      // plain hazard-free reads
      rv = '0; rdv = 4'b0110; rda[1] = 5'd1; rda[2] = 5'd20;
      #1;
      chk("plain_rd_ready", 128'(rd_ready), 1);
      tick();
      rdv = '0;
      #1;
      chk("plain_rdv", 128'(rdvo), 128'b0110);
      chk("plain_rd1", 128'(rdd[1]), 128'h100);
      chk("plain_rd2", 128'(rdd[2]), 0);
      // write/read hazard on addr 3
      rv = 8'h01; ra[0] = 5'd3; rdt[0] = 32'hDEAD; rdv = 4'b0001; rda[0] = 5'd3;
      #1;
      chk("haz_req_ready", 128'(rr), 128'h01);
`ifdef RAM_CTRL_FWD_EN
      chk("haz_rd_ready", 128'(rd_ready), 1);
      tick();
      rv = '0; rdv = '0;
      #1;
      chk("haz_rdv", 128'(rdvo), 128'b0001);
      chk("haz_fwd_data", 128'(rdd[0]), 128'hDEAD);
`else
      chk("haz_rd_ready", 128'(rd_ready), 0);
      tick();
      rv = '0;
      #1;
      chk("haz_retry_rd_ready", 128'(rd_ready), 1);
      chk("haz_stalled_rdv", 128'(rdvo), 0);
      tick();
      rdv = '0;
      #1;
      chk("haz_rdv", 128'(rdvo), 128'b0001);
      chk("haz_ram_data", 128'(rdd[0]), 128'hDEAD);
`endif
      // reset mid-RUN with a read in flight
      rdv = 4'b0001; rda[0] = 5'd20;
      tick();
      rst = 1'b1; rv = 8'hFF;
      #1;
      chk("mid_inflight_rdv", 128'(rdvo), 128'b0001);
      chk("mid_init_done", 128'(init_done), 0);
      chk("mid_req_ready", 128'(rr), 0);
      chk("mid_wr_en", 128'(we), 0);
      chk("mid_rd_ready", 128'(rd_ready), 0);
      tick();
      chk("mid_rdv_clear", 128'(rdvo), 0);
      rst = 1'b0; rv = '0; rdv = '0;
      #1;
      chk("mid_sweep_wr_en", 128'(we), 128'hF);
      chk("mid_sweep_addr", 128'(wa), 128'({5'd3, 5'd2, 5'd1, 5'd0}));
      chk("mid_sweep_done", 128'(init_done), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
